// File: rtl/vec_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_wb_pkg
// Purpose  : Shared types and helpers for the vector register-file writeback.
// Revision : 1.0
// ============================================================================
package vec_wb_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int NUM_REGS   = 8;

   typedef enum logic {
      GRANT_EX  = 1'b0,
      GRANT_MEM = 1'b1
   } grant_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] vec;
      vec       = '0;
      vec[addr] = 1'b1;
      return vec;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo2
// Purpose  : Two-entry writeback request FIFO; exposes every entry for hazards.
// Revision : 1.0
// ============================================================================
module wb_fifo2
   import vec_wb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_push,
   input  logic [REG_ADDR_W-1:0]       i_push_addr,
   input  logic [WIDTH-1:0]            i_push_data,
   input  logic                        i_pop,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [REG_ADDR_W-1:0]       o_head_addr,
   output logic [WIDTH-1:0]            o_head_data,
   output logic [1:0]                  o_ent_valid,
   output logic [1:0][REG_ADDR_W-1:0]  o_ent_addr
);

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [WIDTH-1:0]      data;
   } wb_req_t;

   wb_req_t    r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop  & ~o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: validity is tracked entirely by the count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= '{addr: i_push_addr, data: i_push_data};
   end

   assign o_head_addr = r_mem[r_rd_ptr].addr;
   assign o_head_data = r_mem[r_rd_ptr].data;

   for (genvar i = 0; i < 2; i++) begin : g_ent
      assign o_ent_valid[i] = (r_count == 2'd2) ||
                              ((r_count == 2'd1) && (r_rd_ptr == 1'(i)));
      assign o_ent_addr[i]  = r_mem[i].addr;
   end

endmodule
`default_nettype wire

// File: rtl/vec_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vec_wb_arbiter
// Purpose  : Round-robin EX/MEM writeback arbiter feeding one register-file port.
// Revision : 1.0
// ============================================================================
module vec_wb_arbiter
   import vec_wb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [REG_ADDR_W-1:0] ex_addr,
   input  logic [WIDTH-1:0]      ex_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]      mem_data,
   output logic                  we,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]      wr_data,
   output logic [NUM_REGS-1:0]   pending,
   output logic                  idle
);

   logic                        w_ex_full,  w_ex_empty;
   logic                        w_mem_full, w_mem_empty;
   logic [REG_ADDR_W-1:0]       w_ex_head_addr, w_mem_head_addr;
   logic [WIDTH-1:0]            w_ex_head_data, w_mem_head_data;
   logic [1:0]                  w_ex_ent_valid, w_mem_ent_valid;
   logic [1:0][REG_ADDR_W-1:0]  w_ex_ent_addr,  w_mem_ent_addr;
   logic                        w_grant_ex, w_grant_mem;
   logic [NUM_REGS-1:0]         w_pending;

   grant_t                      r_last_grant;
   logic                        r_we;
   logic [REG_ADDR_W-1:0]       r_wr_addr;
   logic [WIDTH-1:0]            r_wr_data;

   wb_fifo2 #(.WIDTH(WIDTH)) u_ex_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (ex_valid & ~w_ex_full),
      .i_push_addr (ex_addr),
      .i_push_data (ex_data),
      .i_pop       (w_grant_ex),
      .o_full      (w_ex_full),
      .o_empty     (w_ex_empty),
      .o_head_addr (w_ex_head_addr),
      .o_head_data (w_ex_head_data),
      .o_ent_valid (w_ex_ent_valid),
      .o_ent_addr  (w_ex_ent_addr)
   );

   wb_fifo2 #(.WIDTH(WIDTH)) u_mem_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (mem_valid & ~w_mem_full),
      .i_push_addr (mem_addr),
      .i_push_data (mem_data),
      .i_pop       (w_grant_mem),
      .o_full      (w_mem_full),
      .o_empty     (w_mem_empty),
      .o_head_addr (w_mem_head_addr),
      .o_head_data (w_mem_head_data),
      .o_ent_valid (w_mem_ent_valid),
      .o_ent_addr  (w_mem_ent_addr)
   );

   // Under contention the port that did not win last time takes the slot.
   assign w_grant_ex  = ~w_ex_empty  & (w_mem_empty | (r_last_grant == GRANT_MEM));
   assign w_grant_mem = ~w_mem_empty & (w_ex_empty  | (r_last_grant == GRANT_EX));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= GRANT_MEM;
         r_we         <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
      end else if (w_grant_ex) begin
         r_last_grant <= GRANT_EX;
         r_we         <= 1'b1;
         r_wr_addr    <= w_ex_head_addr;
         r_wr_data    <= w_ex_head_data;
      end else if (w_grant_mem) begin
         r_last_grant <= GRANT_MEM;
         r_we         <= 1'b1;
         r_wr_addr    <= w_mem_head_addr;
         r_wr_data    <= w_mem_head_data;
      end else begin
         r_we         <= 1'b0;
      end
   end

   always_comb begin
      w_pending = '0;
      for (int i = 0; i < 2; i++) begin
         if (w_ex_ent_valid[i])  w_pending = w_pending | reg_onehot(w_ex_ent_addr[i]);
         if (w_mem_ent_valid[i]) w_pending = w_pending | reg_onehot(w_mem_ent_addr[i]);
      end
      if (r_we) w_pending = w_pending | reg_onehot(r_wr_addr);
   end

   assign ex_ready  = ~w_ex_full;
   assign mem_ready = ~w_mem_full;
   assign we        = r_we;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign pending   = w_pending;
   assign idle      = w_ex_empty & w_mem_empty & ~r_we;

endmodule
`default_nettype wire
